scnn_output_compressor: RTL and testbench

Drain-side sparse encoder for the 4-PE SCNN controller. It captures the dense 64-entry, 32-bit output-accumulator array and applies ReLU, shift and saturation to 16-bit activations. It then streams only the nonzero results as (index, value) beats over a valid/ready handshake. The stream is the compressed activation format that feeds the next layer's input.

---
 rtl/scnn_output_compressor_if.sv | 31 +++
 rtl/scnn_output_compressor.sv | 147 ++++++++++++++
 tb/tb_scnn_output_compressor.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scnn_output_compressor_if.sv
// Request/stream bundle between the SCNN drain controller and the output compressor.
// The master drives start/plane data/out_ready; the slave returns status and the sparse beat stream.
interface scnn_output_compressor_if #(
    parameter int N     = 64,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    localparam int IW = $clog2(N);

    logic                      start;
    logic [7:0]                dim;
    logic [N-1:0][IN_W-1:0]    outputs;
    logic                      busy;
    logic                      out_valid;
    logic                      out_ready;
    logic [IW-1:0]             out_index;
    logic [OUT_W-1:0]          out_value;
    logic                      out_last;
    logic                      done;
    logic [IW:0]               nnz_count;

    modport master (
        output start, dim, outputs, out_ready,
        input  busy, out_valid, out_index, out_value, out_last, done, nnz_count
    );

    modport slave (
        input  start, dim, outputs, out_ready,
        output busy, out_valid, out_index, out_value, out_last, done, nnz_count
    );
endinterface

// File: rtl/scnn_output_compressor.sv
// Captures a dense accumulator plane, quantizes (ReLU/shift/saturate) and streams nonzero (index,value) beats.
// First index shows 1 cycle after start, one index per cycle; a stalled beat holds until out_ready.
module scnn_output_compressor #(
    parameter int N     = 64,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    scnn_output_compressor_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;
    localparam logic [IN_W-1:0] QMAX     = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic [N-1:0]    LSB_ONLY = N'(1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                  r_state;
    logic [N-1:0][OUT_W-1:0] r_q;
    logic [N-1:0]            r_mask;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           r_last_idx;
    logic                    r_busy;
    logic                    r_out_valid;
    logic [IW-1:0]           r_out_index;
    logic [OUT_W-1:0]        r_out_value;
    logic                    r_out_last;
    logic                    r_done;
    logic [CW-1:0]           r_nnz;

    logic [15:0]             w_sq;
    logic [CW-1:0]           w_len;
    logic [N-1:0][OUT_W-1:0] w_q;
    logic [N-1:0]            w_mask;
    logic [CW-1:0]           w_nnz;
    logic                    w_accept;
    logic                    w_advance;
    logic [IW-1:0]           w_next_idx;

    function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] y;
        y = x >> SHIFT;
        if (x[IN_W-1])
            return '0;
        else if (y > QMAX)
            return QMAX[OUT_W-1:0];
        else
            return y[OUT_W-1:0];
    endfunction

    assign w_sq  = {8'd0, bus.dim} * {8'd0, bus.dim};
    assign w_len = (w_sq > 16'(N)) ? CW'(N) : w_sq[CW-1:0];

    always_comb begin
        w_q    = '0;
        w_mask = '0;
        w_nnz  = '0;
        for (int i = 0; i < N; i++) begin
            w_q[i]    = quant(bus.outputs[i]);
            w_mask[i] = (w_q[i] != '0) && (CW'(i) < w_len);
            w_nnz     = w_nnz + CW'(w_mask[i]);
        end
    end

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    // An empty slot never waits for the sink; a presented beat waits for out_ready.
    assign w_advance  = !r_out_valid || bus.out_ready;
    assign w_next_idx = r_idx + IW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept)
            r_q <= w_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_idx       <= '0;
            r_last_idx  <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_value <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_nnz       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mask      <= w_mask;
                        r_nnz       <= w_nnz;
                        r_idx       <= '0;
                        r_last_idx  <= IW'(w_len - CW'(1));
                        r_busy      <= 1'b1;
                        r_out_index <= '0;
                        if (w_len == '0) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_state     <= S_SCAN;
                            r_out_valid <= w_mask[0];
                            r_out_value <= w_q[0];
                            r_out_last  <= (w_mask == LSB_ONLY);
                        end
                    end
                end
                S_SCAN: begin
                    if (w_advance) begin
                        if (r_idx == r_last_idx) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_idx       <= w_next_idx;
                            r_out_index <= w_next_idx;
                            r_out_valid <= r_mask[w_next_idx];
                            r_out_value <= r_q[w_next_idx];
                            // Last beat: this bit set and nothing above it.
                            r_out_last  <= ((r_mask >> w_next_idx) == LSB_ONLY);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_index = r_out_index;
    assign bus.out_value = r_out_value;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;
    assign bus.nnz_count = r_nnz;
endmodule

// File: tb/tb_scnn_output_compressor.sv
// Bench for scnn_output_compressor: directed planes plus random planes checked against a cycle timeline model.
module tb_scnn_output_compressor;
    localparam int N     = 64;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 0;
    localparam int MAXC  = 256;

    logic clk = 1'b0;
    logic rst;

    scnn_output_compressor_if #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    scnn_output_compressor #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0][IN_W-1:0] acc;
    int rdy_pat [MAXC];
    bit m_valid [MAXC];
    int m_idx   [MAXC];
    int m_val   [MAXC];
    bit m_last  [MAXC];
    int m_done;
    int m_nnz;
    int obs_done;
    int obs_nnz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_quant(input logic [31:0] x);
        int s;
        s = x;
        if (s < 0) return 0;
        s = s >>> SHIFT;
        return (s > 32767) ? 32767 : s;
    endfunction

    // Expected per-cycle view (offset k after the start edge) from the plane contents and ready pattern.
    task automatic build_model(input int dim);
        int L, c, lastj;
        int q [N];
        L = dim * dim;
        if (L > N) L = N;
        for (int j = 0; j < N; j++) q[j] = ref_quant(acc[j]);
        lastj = -1;
        m_nnz = 0;
        for (int j = 0; j < L; j++)
            if (q[j] != 0) begin
                lastj = j;
                m_nnz++;
            end
        for (int i = 0; i < MAXC; i++) begin
            m_valid[i] = 0; m_idx[i] = 0; m_val[i] = 0; m_last[i] = 0;
        end
        c = 1;
        for (int j = 0; j < L; j++) begin
            if (q[j] == 0) c++;
            else begin
                do begin
                    m_valid[c] = 1; m_idx[c] = j; m_val[c] = q[j]; m_last[c] = (j == lastj);
                    c++;
                end while (rdy_pat[c-1] == 0);
            end
        end
        m_done = c;
    endtask

    task automatic ready_all();
        for (int i = 0; i < MAXC; i++) rdy_pat[i] = 1;
    endtask

    task automatic ready_random();
        for (int i = 0; i < MAXC; i++) rdy_pat[i] = (i > 150) ? 1 : int'($urandom_range(0, 3) != 0);
    endtask

    task automatic random_plane();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: acc[i] = 32'd0;
                3:       acc[i] = -32'($urandom_range(1, 1000000));
                4:       acc[i] = 32'h0001_0000 + 32'($urandom_range(0, 65535));
                5:       acc[i] = 32'h0000_7FFF;
                6:       acc[i] = 32'h0000_8000;
                default: acc[i] = 32'($urandom_range(1, 100));
            endcase
        end
    endtask

    task automatic run_plane(input string tag, input int dim);
        build_model(dim);
        bus.dim     = 8'(dim);
        bus.outputs = acc;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.out_ready = (rdy_pat[1] != 0);
        obs_done = 0;
        obs_nnz  = -1;
        for (int k = 1; k <= m_done + 1; k++) begin
            @(negedge clk);
            check($sformatf("%s.valid@%0d", tag, k), 32'(bus.out_valid), 32'(m_valid[k]));
            if (m_valid[k]) begin
                check($sformatf("%s.index@%0d", tag, k), 32'(bus.out_index), 32'(m_idx[k]));
                check($sformatf("%s.value@%0d", tag, k), 32'(bus.out_value), 32'(m_val[k]));
                check($sformatf("%s.last@%0d", tag, k), 32'(bus.out_last), 32'(m_last[k]));
            end
            check($sformatf("%s.busy@%0d", tag, k), 32'(bus.busy), 32'(k <= m_done));
            check($sformatf("%s.done@%0d", tag, k), 32'(bus.done), 32'(k == m_done));
            if (bus.done && obs_done == 0) obs_done = k;
            if (k == m_done) begin
                check($sformatf("%s.nnz", tag), 32'(bus.nnz_count), 32'(m_nnz));
                obs_nnz = int'(bus.nnz_count);
            end
            if (k <= m_done) begin
                @(posedge clk);
                #1;
                bus.out_ready = (rdy_pat[k+1] != 0);
            end
        end
    endtask

    task automatic load_sparse();
        acc = '0;
        acc[2]  = 32'd2;
        acc[4]  = 32'd5;
        acc[11] = 32'd11;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"},  32'(bus.busy),      32'd0);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".index"}, 32'(bus.out_index), 32'd0);
        check({tag, ".value"}, 32'(bus.out_value), 32'd0);
        check({tag, ".last"},  32'(bus.out_last),  32'd0);
        check({tag, ".done"},  32'(bus.done),      32'd0);
        check({tag, ".nnz"},   32'(bus.nnz_count), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.dim       = 8'd0;
        bus.outputs   = '0;
        bus.out_ready = 1'b1;
        acc           = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        ready_all();
        acc = '0;
        run_plane("zero", 8);
        check("zero.done_cycle", 32'(obs_done), 32'd65);
        check("zero.nnz_final", 32'(obs_nnz), 32'd0);

        load_sparse();
        run_plane("sparse", 8);
        check("sparse.done_cycle", 32'(obs_done), 32'd65);
        check("sparse.nnz_final", 32'(obs_nnz), 32'd3);

        acc = '0;
        acc[0] = 32'hFFFF_FFF9;
        acc[1] = 32'h0001_0000;
        acc[5] = 32'd3;
        run_plane("sat", 8);
        check("sat.nnz_final", 32'(obs_nnz), 32'd2);

        load_sparse();
        rdy_pat[3] = 0; rdy_pat[4] = 0; rdy_pat[5] = 0;
        run_plane("stall", 8);
        check("stall.done_cycle", 32'(obs_done), 32'd68);
        ready_all();

        acc = '0;
        acc[8] = 32'd4;
        acc[9] = 32'd6;
        run_plane("dim3", 3);
        check("dim3.done_cycle", 32'(obs_done), 32'd10);
        check("dim3.nnz_final", 32'(obs_nnz), 32'd1);
        run_plane("dim0", 0);
        check("dim0.done_cycle", 32'(obs_done), 32'd1);
        check("dim0.nnz_final", 32'(obs_nnz), 32'd0);

        // Reset during the scan of a populated plane, with a colliding start.
        load_sparse();
        bus.dim     = 8'd8;
        bus.outputs = acc;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        @(negedge clk);
        check("midrst.start_ignored", 32'(bus.busy), 32'd0);
        run_plane("restart", 8);
        check("restart.nnz_final", 32'(obs_nnz), 32'd3);

        random_plane();
        ready_all();
        run_plane("clamp", 255);
        check("clamp.done_cycle", 32'(obs_done), 32'd65);

        for (int p = 0; p < 12; p++) begin
            random_plane();
            ready_random();
            run_plane($sformatf("rand%0d", p), int'($urandom_range(0, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
